nibble_sub_sequencer: RTL

Sequential front/back end for the 4-bit combinational substitution stage (b -> a nibble lookup). It accepts WORD_W-bit words over a valid/ready handshake and presents them to the substitution stage one nibble per cycle, least significant nibble first. It reassembles the substituted nibbles into a WORD_W-bit result and offers that result downstream over a second valid/ready handshake. It sits directly upstream of the lookup, driving its `b` input, and directly downstream of it, consuming its `a` output.

---
 rtl/nibble_sub_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/nibble_sub_sequencer.sv
// Sequences a word through a 4-bit substitution stage, one nibble per cycle (LSB first),
// and reassembles the substituted nibbles into a result offered over valid/ready.
module nibble_sub_sequencer #(
  parameter int WORD_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  output logic [3:0]        sub_b_o,
  input  logic [3:0]        sub_a_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              busy_o
);

  localparam int NIB   = WORD_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [WORD_W-1:0]  result_q, result_d;
  logic [WORD_W-1:0]  out_q, out_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_nib;

  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      result_q <= '0;
      out_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      out_q    <= out_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    result_d    = result_q;
    out_d       = out_q;
    idx_d       = idx_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    sub_b_o     = 4'b0000;
    unique case (state_q)
      IDLE: begin
        in_ready_o = !rst_i;
        if (in_valid_i && !rst_i) begin
          shift_d  = in_data_i;
          result_d = '0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sub_b_o                 = shift_q[3:0];
        result_d[4*idx_q +: 4]  = sub_a_i;
        shift_d                 = shift_q >> 4;
        idx_d                   = idx_q + 1'b1;
        // Separate output register keeps the last result visible after the next accept clears result_q.
        if (last_nib) begin
          out_d   = result_d;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data_o = out_q;
  assign busy_o     = (state_q != IDLE);

endmodule
